// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   OPC_JAL / OPC_BRANCH : RV32 opcodes recognised by the static predictor
//   NOP_INSTR            : addi x0,x0,0, loaded into IF/ID when it is empty
//   if_state_e           : fetch FSM state encoding
//   word_align()         : clears the two byte-offset bits of an address
package if_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/static_predictor.sv
// Static next-PC predictor for one fetched word (purely combinational).
//   pc      in  32  address the word was fetched from
//   instr   in  32  fetched instruction word
//   taken   out 1   prediction redirected the fetch stream
//   next_pc out 32  predicted address of the following fetch
// JAL and backward conditional branches are predicted taken; everything
// else (JALR, forward branches, non-control words) falls through to pc+4.
// With PREDICT_EN=0 the output is always pc+4, not taken.
module static_predictor
  import if_pkg::*;
#(
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        taken,
  output logic [31:0] next_pc
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    taken   = 1'b0;
    next_pc = pc + 32'd4;
    if (PREDICT_EN) begin
      if (instr[6:0] == OPC_JAL) begin
        taken   = 1'b1;
        next_pc = pc + imm_j;
      end else if ((instr[6:0] == OPC_BRANCH) && instr[31]) begin
        // sign bit set means a negative offset: loop back-edge
        taken   = 1'b1;
        next_pc = pc + imm_b;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding
// req/gnt/rvalid instruction port and loads the IF/ID pipeline register.
//   clk, reset_n              clock, asynchronous active-low reset
//   hazard_stall              hold IF/ID, no new delivery
//   hazard_flush              clear IF/ID, kill the in-flight fetch
//   redirect_valid/_pc        EX correction; implies flush, [1:0] ignored
//   imem_req/_addr/_gnt       fetch request channel (addr = pc_q)
//   imem_rvalid/_rdata        fetch response channel
//   IF_ID_*                   PC, word, prediction flag, valid of IF/ID
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | first cycle after reset release, nothing requested yet
// REQ   | imem_req high at pc_q, waiting for gnt
// WAIT  | request accepted, waiting for rvalid (kill drops the reply)
// HOLD  | reply parked in the 1-entry buffer while the pipe is stalled
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          PREDICT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hazard_stall,
  input  logic        hazard_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_jump_branch_taken,
  output logic        IF_ID_enable_out
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_taken_q, buf_taken_d;

  logic        squash;
  logic        deliver;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_instr;
  logic        dlv_taken;
  logic        pred_taken;
  logic [31:0] pred_next_pc;

  assign squash    = hazard_flush | redirect_valid;
  assign imem_addr = pc_q;

  static_predictor #(
    .PREDICT_EN(PREDICT_EN)
  ) u_predictor (
    .pc     (pc_q),
    .instr  (imem_rdata),
    .taken  (pred_taken),
    .next_pc(pred_next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_taken_d = buf_taken_q;
    imem_req    = 1'b0;
    deliver     = 1'b0;
    dlv_pc      = pc_q;
    dlv_instr   = imem_rdata;
    dlv_taken   = pred_taken;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = ST_WAIT;
          // a squash landing on the grant cycle still has a reply coming
          kill_d  = squash;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !squash) begin
            pc_d = word_align(pred_next_pc);
            if (hazard_stall) begin
              state_d     = ST_HOLD;
              buf_pc_d    = pc_q;
              buf_instr_d = imem_rdata;
              buf_taken_d = pred_taken;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (squash) begin
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (squash) begin
          // refetch the dropped word unless a redirect overrides below
          state_d = ST_REQ;
          pc_d    = buf_pc_q;
        end else if (!hazard_stall) begin
          state_d   = ST_REQ;
          deliver   = 1'b1;
          dlv_pc    = buf_pc_q;
          dlv_instr = buf_instr_q;
          dlv_taken = buf_taken_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_pc_q    <= 32'd0;
      buf_instr_q <= NOP_INSTR;
      buf_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_taken_q <= buf_taken_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IF_ID_PC                <= 32'd0;
      IF_ID_Instruction       <= NOP_INSTR;
      IF_ID_jump_branch_taken <= 1'b0;
      IF_ID_enable_out        <= 1'b0;
    end else if (squash) begin
      IF_ID_PC                <= 32'd0;
      IF_ID_Instruction       <= NOP_INSTR;
      IF_ID_jump_branch_taken <= 1'b0;
      IF_ID_enable_out        <= 1'b0;
    end else if (hazard_stall) begin
      IF_ID_enable_out        <= IF_ID_enable_out;
    end else if (deliver) begin
      IF_ID_PC                <= dlv_pc;
      IF_ID_Instruction       <= dlv_instr;
      IF_ID_jump_branch_taken <= dlv_taken;
      IF_ID_enable_out        <= 1'b1;
    end else begin
      IF_ID_enable_out        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (prediction on / off) share all
// handshake and data stimulus; a behavioural model tracks each one.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_8093;
  localparam logic [31:0] JAL20  = 32'h0200_00EF;
  localparam logic [31:0] BNE_M8 = 32'hFE20_9CE3;
  localparam logic [31:0] BEQ_P8 = 32'h0020_8463;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hazard_stall = 1'b0, hazard_flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;

  logic        req0, req1, tk0, tk1, en0, en1;
  logic [31:0] addr0, addr1, ifpc0, ifpc1, ifin0, ifin1;

  if_stage #(.RESET_PC(RST_PC), .PREDICT_EN(1'b1)) u_dut_pred (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall),
    .hazard_flush(hazard_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(req0), .imem_addr(addr0),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_PC(ifpc0), .IF_ID_Instruction(ifin0),
    .IF_ID_jump_branch_taken(tk0), .IF_ID_enable_out(en0));

  if_stage #(.RESET_PC(RST_PC), .PREDICT_EN(1'b0)) u_dut_flat (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall),
    .hazard_flush(hazard_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(req1), .imem_addr(addr1),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_PC(ifpc1), .IF_ID_Instruction(ifin1),
    .IF_ID_jump_branch_taken(tk1), .IF_ID_enable_out(en1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: fetch-stream view of each instance
  bit          m_started[2], m_out[2], m_doom[2], m_park[2], m_ptk[2];
  logic [31:0] m_pc[2], m_ppc[2], m_pin[2];
  logic [31:0] m_ifpc[2], m_ifin[2];
  bit          m_tk[2], m_en[2];

  // responder / knobs
  bit          r_pend = 1'b0;
  int          r_cnt = 0;
  int          p_gnt = 100, dly_min = 0, dly_max = 0;
  logic [31:0] force_q[$];

  function automatic bit m_req(input int i);
    return m_started[i] && !m_out[i] && !m_park[i];
  endfunction

  function automatic void mpredict(input bit pen, input logic [31:0] pc, input logic [31:0] w,
                                   output bit tk, output logic [31:0] npc);
    logic [31:0] off;
    tk  = 1'b0;
    off = 32'd4;
    if (pen && w[6:0] == 7'b1101111) begin
      tk  = 1'b1;
      off = (w[31] ? 32'hFFF0_0000 : 32'd0) + {24'd0, w[19:12]} * 32'd4096
          + {31'd0, w[20]} * 32'd2048 + {22'd0, w[30:21]} * 32'd2;
    end else if (pen && w[6:0] == 7'b1100011 && w[31]) begin
      tk  = 1'b1;
      off = 32'hFFFF_F000 + {31'd0, w[7]} * 32'd2048
          + {26'd0, w[30:25]} * 32'd32 + {28'd0, w[11:8]} * 32'd2;
    end
    npc = pc + off;
    npc[1:0] = 2'b00;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(3, 0))
      0: begin w[6:0] = 7'b1101111; w[21] = 1'b0; end
      1: begin w[6:0] = 7'b1100011; w[8] = 1'b0; end
      2: w[6:0] = 7'b1100111;
      default: w[6:0] = 7'b0010011;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0; m_out[i] = 0; m_doom[i] = 0; m_park[i] = 0; m_ptk[i] = 0;
      m_pc[i] = RST_PC; m_ppc[i] = 0; m_pin[i] = 0;
      m_ifpc[i] = 0; m_ifin[i] = TB_NOP; m_tk[i] = 0; m_en[i] = 0;
    end
    r_pend = 1'b0;
    r_cnt  = 0;
  endtask

  task automatic mstep(input int i, input bit st, input bit fl, input bit rd,
                       input logic [31:0] rpc, input bit gnt, input bit rv, input logic [31:0] w);
    bit kn, dl, ptk, dtk;
    logic [31:0] npc, dpc, din;
    kn = fl | rd; dl = 0; dtk = 0; dpc = 0; din = 0;
    mpredict(i == 0, m_pc[i], w, ptk, npc);
    if (!m_started[i]) begin
      m_started[i] = 1;
    end else if (m_park[i]) begin
      if (kn) begin
        m_park[i] = 0;
        m_pc[i] = m_ppc[i];
      end else if (!st) begin
        m_park[i] = 0;
        dl = 1; dpc = m_ppc[i]; din = m_pin[i]; dtk = m_ptk[i];
      end
    end else if (m_out[i]) begin
      if (rv) begin
        m_out[i] = 0;
        if (m_doom[i]) m_doom[i] = 0;
        else if (!kn) begin
          if (st) begin
            m_park[i] = 1; m_ppc[i] = m_pc[i]; m_pin[i] = w; m_ptk[i] = ptk;
          end else begin
            dl = 1; dpc = m_pc[i]; din = w; dtk = ptk;
          end
          m_pc[i] = npc;
        end
      end else if (kn) begin
        m_doom[i] = 1;
      end
    end else if (gnt) begin
      m_out[i] = 1;
      if (kn) m_doom[i] = 1;
    end
    if (rd) m_pc[i] = {rpc[31:2], 2'b00};
    if (kn) begin
      m_ifpc[i] = 0; m_ifin[i] = TB_NOP; m_tk[i] = 0; m_en[i] = 0;
    end else if (!st) begin
      if (dl) begin
        m_ifpc[i] = dpc; m_ifin[i] = din; m_tk[i] = dtk; m_en[i] = 1;
      end else begin
        m_en[i] = 0;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic rq, input logic [31:0] ad,
                          input logic [31:0] pc, input logic [31:0] in, input logic t, input logic e);
    string nm;
    nm = (i == 0) ? "pred" : "flat";
    check_eq({nm, " imem_req"}, 32'(rq), 32'(m_req(i)));
    check_eq({nm, " imem_addr"}, ad, m_pc[i]);
    check_eq({nm, " IF_ID_PC"}, pc, m_ifpc[i]);
    check_eq({nm, " IF_ID_Instruction"}, in, m_ifin[i]);
    check_eq({nm, " IF_ID_taken"}, 32'(t), 32'(m_tk[i]));
    check_eq({nm, " IF_ID_enable"}, 32'(e), 32'(m_en[i]));
  endtask

  // one clock: compare at negedge, drive, advance model, move to next negedge
  task automatic cycle(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
    bit rv, gnt;
    logic [31:0] w;
    cmp_inst(0, req0, addr0, ifpc0, ifin0, tk0, en0);
    cmp_inst(1, req1, addr1, ifpc1, ifin1, tk1, en1);
    rv = 0;
    if (r_pend) begin
      if (r_cnt == 0) begin rv = 1; r_pend = 0; end
      else r_cnt--;
    end
    gnt = m_req(0) && (int'($urandom_range(99, 0)) < p_gnt);
    if (gnt) begin
      r_pend = 1;
      r_cnt  = int'($urandom_range(dly_max, dly_min));
    end
    if (rv && force_q.size() > 0) w = force_q.pop_front();
    else w = rand_word();
    hazard_stall = st; hazard_flush = fl; redirect_valid = rd; redirect_pc = rpc;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = w;
    mstep(0, st, fl, rd, rpc, gnt, rv, w);
    mstep(1, st, fl, rd, rpc, gnt, rv, w);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " pred req"}, 32'(req0), 32'd0);
    check_eq({tag, " pred addr"}, addr0, RST_PC);
    check_eq({tag, " pred IF_ID_PC"}, ifpc0, 32'd0);
    check_eq({tag, " pred IF_ID_Instr"}, ifin0, TB_NOP);
    check_eq({tag, " pred taken"}, 32'(tk0), 32'd0);
    check_eq({tag, " pred enable"}, 32'(en0), 32'd0);
    check_eq({tag, " flat req"}, 32'(req1), 32'd0);
    check_eq({tag, " flat addr"}, addr1, RST_PC);
    check_eq({tag, " flat IF_ID_Instr"}, ifin1, TB_NOP);
    check_eq({tag, " flat enable"}, 32'(en1), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    hazard_stall = 0; hazard_flush = 0; redirect_valid = 0;
    imem_gnt = 0; imem_rvalid = 0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(negedge clk);
    check_reset_vals({tag, " held"});
    reset_n = 1'b1;
  endtask

  task automatic wait_pend(input bit want_rv_next);
    int g;
    g = 0;
    while (!(r_pend && (!want_rv_next || r_cnt == 0)) && g < 50) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      g++;
    end
    check_eq("wait bound", 32'(g < 50), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset");

    // zero-wait memory, straight-line code then a JAL at 0x10
    p_gnt = 100; dly_min = 0; dly_max = 0;
    force_q = '{ADDI, ADDI, ADDI, ADDI, JAL20, ADDI, ADDI};
    run(16);

    // backward BNE at 0x40, forward BEQ next
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    force_q = '{BNE_M8, BEQ_P8, ADDI, ADDI};
    run(10);

    // stall lands on the reply cycle, held for several cycles
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    force_q = '{ADDI, ADDI, ADDI, ADDI, ADDI};
    wait_pend(1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run(6);

    // redirect while waiting on a slow reply
    dly_min = 2; dly_max = 2;
    wait_pend(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    run(10);

    // flush while parked, and flush while waiting
    wait_pend(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    run(4);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    run(8);

    // PC wrap at the top of the address space
    dly_min = 0; dly_max = 0;
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    force_q = '{ADDI, ADDI, ADDI};
    run(8);

    // reset asserted mid-fetch
    dly_min = 2; dly_max = 2;
    wait_pend(1'b0);
    do_reset("reset in WAIT");
    run(6);

    // randomized segments
    for (int seg = 0; seg < 15; seg++) begin
      int ps, pf, pr;
      p_gnt   = int'($urandom_range(100, 30));
      dly_min = 0;
      dly_max = int'($urandom_range(3, 0));
      ps = int'($urandom_range(40, 0));
      pf = int'($urandom_range(8, 0));
      pr = int'($urandom_range(8, 0));
      for (int c = 0; c < 200; c++) begin
        cycle(int'($urandom_range(99, 0)) < ps, int'($urandom_range(99, 0)) < pf,
              int'($urandom_range(99, 0)) < pr, $urandom);
      end
      if (seg == 7) do_reset("reset random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
